dff_reg_arbiter: RTL and testbench

Round-robin arbiter and write sequencer for a shared WIDTH-bit register made of asynchronously cleared D flip-flops. NREQ requesters compete for write access through a four-phase req/gnt/ack handshake. A separate level-sensitive clear request zeroes the register and takes priority over writes whenever the arbiter is idle. The block sits between the requester logic and the storage flops, and drives both Q and not_Q of the shared register.

---
 rtl/dff_reg_arbiter_if.sv | 26 ++
 rtl/dff_reg_arbiter.sv | 131 +++++++++++++
 tb/tb_dff_reg_arbiter.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/dff_reg_arbiter_if.sv
// Bus bundle between the requesters and the shared-register arbiter.
// The master side drives requests, write data and clear; the slave side
// (the arbiter) returns grant/ack, the register value and its complement.
interface dff_reg_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] wdata;
    logic                  clr_req;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       ack;
    logic [WIDTH-1:0]      Q;
    logic [WIDTH-1:0]      not_Q;
    logic                  busy;

    modport master (
        output req, wdata, clr_req,
        input  gnt, ack, Q, not_Q, busy
    );

    modport slave (
        input  req, wdata, clr_req,
        output gnt, ack, Q, not_Q, busy
    );
endinterface

// File: rtl/dff_reg_arbiter.sv
// Round-robin arbiter and write sequencer for one shared WIDTH-bit register.
// Requesters use a four-phase req/gnt/ack handshake; a level clear request
// zeroes the register and beats any pending write while the arbiter is idle.
// Ownership and the last-winner pointer are both kept one-hot so that the
// rotating priority search reduces to mask-and-isolate-lowest-bit arithmetic.
module dff_reg_arbiter #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
) (
    input  logic                clk,
    input  logic                clr_n,
    dff_reg_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WAIT  = 2'd2,
        CLEAR = 2'd3
    } state_t;

    state_t            state_q, state_d;
    // gnt_q doubles as the one-hot owner while a requester holds the register
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic [NREQ-1:0]   last_q, last_d;
    logic [WIDTH-1:0]  q_q, q_d;

    logic [NREQ-1:0]       above_last;
    logic [NREQ-1:0]       req_masked;
    logic [NREQ-1:0]       req_pick;
    logic [NREQ-1:0]       winner_oh;
    logic                  owner_req;
    logic [NREQ*WIDTH-1:0] wdata_masked;
    logic [WIDTH-1:0]      wdata_sel;

    // Bits strictly above the last winner. When the last winner is the top
    // requester the shift overflows to zero and the mask becomes empty, so
    // the search naturally wraps to the full request vector.
    assign above_last = ~((last_q << 1) - NREQ'(1));
    assign req_masked = bus.req & above_last;
    assign req_pick   = (req_masked != '0) ? req_masked : bus.req;
    assign winner_oh  = req_pick & (~req_pick + NREQ'(1));

    // Only the owner's request line matters once a grant is out
    assign owner_req = |(bus.req & gnt_q);

    // Zero every write-data slice except the owner's
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_wmask
        assign wdata_masked[gi*WIDTH +: WIDTH] =
            {WIDTH{gnt_q[gi]}} & bus.wdata[gi*WIDTH +: WIDTH];
    end

    // OR the masked slices together to select the owner's write data
    always_comb begin
        wdata_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            wdata_sel = wdata_sel | wdata_masked[i*WIDTH +: WIDTH];
        end
    end

    // Next-state and register-update decisions for the handshake sequencer
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ack_d   = ack_q;
        last_d  = last_q;
        q_d     = q_q;
        case (state_q)
            IDLE: begin
                if (bus.clr_req) begin
                    q_d     = '0;
                    state_d = CLEAR;
                end else if (bus.req != '0) begin
                    gnt_d   = winner_oh;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (owner_req) begin
                    q_d     = wdata_sel;
                    ack_d   = gnt_q;
                    state_d = WAIT;
                end else begin
                    // Aborted request: hand priority on without writing
                    gnt_d   = '0;
                    last_d  = gnt_q;
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (!owner_req) begin
                    gnt_d   = '0;
                    ack_d   = '0;
                    last_d  = gnt_q;
                    state_d = IDLE;
                end
            end
            CLEAR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and storage flops; clr_n clears everything regardless of clk
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ack_q   <= '0;
            last_q  <= {1'b1, {(NREQ-1){1'b0}}};
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            last_q  <= last_d;
            q_q     <= q_d;
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.ack   = ack_q;
    assign bus.Q     = q_q;
    assign bus.not_Q = ~q_q;
    assign bus.busy  = (state_q != IDLE);

endmodule

// File: tb/tb_dff_reg_arbiter.sv
// Bench for dff_reg_arbiter: reset and asynchronous reset checks, a table of
// directed cycle vectors, a round-robin sequence, then randomized traffic
// compared against a transaction-level reference model.
module tb_dff_reg_arbiter;

    localparam int WIDTH = 8;
    localparam int NREQ  = 4;

    logic clk;
    logic clr_n;

    dff_reg_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

    dff_reg_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [3:0] req;
        logic       clr;
        logic [3:0] gnt;
        logic [3:0] ack;
        logic [7:0] q;
        logic       busy;
    } vec_t;

    vec_t       vecs [16];
    logic [7:0] wd [4];

    // Reference model: who owns the register, whether it was written,
    // whether a clear cycle is in progress, and the last owner.
    int         m_owner;
    bit         m_acked;
    bit         m_clearing;
    int         m_last;
    logic [7:0] m_q;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input logic [3:0] e_gnt, input logic [3:0] e_ack,
                             input logic [7:0] e_q, input logic e_busy);
        logic [7:0] e_nq;
        e_nq = ~e_q;
        check({name, ".gnt"},   32'(bus.gnt),   32'(e_gnt));
        check({name, ".ack"},   32'(bus.ack),   32'(e_ack));
        check({name, ".Q"},     32'(bus.Q),     32'(e_q));
        check({name, ".not_Q"}, 32'(bus.not_Q), 32'(e_nq));
        check({name, ".busy"},  32'(bus.busy),  32'(e_busy));
    endtask

    // Next requester after 'last' in circular order that has req set
    function automatic int pick(input logic [3:0] r, input int last);
        for (int d = 1; d <= NREQ; d++) begin
            int idx;
            idx = (last + d) % NREQ;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_step(input logic [3:0] r, input logic clr, input logic [31:0] w);
        if (m_clearing) begin
            m_clearing = 1'b0;
        end else if (m_owner < 0) begin
            if (clr) begin
                m_q        = 8'h00;
                m_clearing = 1'b1;
            end else if (r != 4'b0000) begin
                m_owner = pick(r, m_last);
            end
        end else if (!m_acked) begin
            if (r[m_owner]) begin
                m_q     = w[m_owner*8 +: 8];
                m_acked = 1'b1;
            end else begin
                m_last  = m_owner;
                m_owner = -1;
            end
        end else if (!r[m_owner]) begin
            m_last  = m_owner;
            m_owner = -1;
            m_acked = 1'b0;
        end
    endtask

    initial begin
        int exp_order [6];
        int nack;
        int cyc;
        logic [3:0]  req_r;
        logic        clr_r;
        logic [3:0]  e_gnt;
        logic [3:0]  e_ack;

        wd[0] = 8'hA5; wd[1] = 8'hB1; wd[2] = 8'hC2; wd[3] = 8'hD3;
        exp_order = '{0, 1, 2, 3, 0, 1};

        //              req      clr   gnt      ack      Q      busy
        vecs[0]  = '{4'b0001, 1'b0, 4'b0001, 4'b0000, 8'h00, 1'b1}; // single write: grant
        vecs[1]  = '{4'b0001, 1'b0, 4'b0001, 4'b0001, 8'hA5, 1'b1}; // write + ack
        vecs[2]  = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 8'hA5, 1'b0}; // release
        vecs[3]  = '{4'b0010, 1'b1, 4'b0000, 4'b0000, 8'h00, 1'b1}; // clear beats req
        vecs[4]  = '{4'b0010, 1'b1, 4'b0000, 4'b0000, 8'h00, 1'b0}; // clear done
        vecs[5]  = '{4'b0010, 1'b0, 4'b0010, 4'b0000, 8'h00, 1'b1}; // deferred grant
        vecs[6]  = '{4'b0010, 1'b0, 4'b0010, 4'b0010, 8'hB1, 1'b1};
        vecs[7]  = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 8'hB1, 1'b0};
        vecs[8]  = '{4'b0100, 1'b0, 4'b0100, 4'b0000, 8'hB1, 1'b1}; // abort: grant
        vecs[9]  = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 8'hB1, 1'b0}; // abort: no ack
        vecs[10] = '{4'b1111, 1'b0, 4'b1000, 4'b0000, 8'hB1, 1'b1}; // priority moves to 3
        vecs[11] = '{4'b1000, 1'b0, 4'b1000, 4'b1000, 8'hD3, 1'b1};
        vecs[12] = '{4'b1000, 1'b1, 4'b1000, 4'b1000, 8'hD3, 1'b1}; // clear held in WAIT
        vecs[13] = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 8'hD3, 1'b0}; // release first
        vecs[14] = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 8'h00, 1'b1}; // then clear
        vecs[15] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 8'h00, 1'b0};

        clr_n       = 1'b0;
        bus.req     = 4'b0000;
        bus.clr_req = 1'b0;
        bus.wdata   = {wd[3], wd[2], wd[1], wd[0]};

        // Reset held with random inputs
        for (int i = 0; i < 4; i++) begin
            bus.req     = 4'($urandom_range(0, 15));
            bus.clr_req = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            check_all($sformatf("reset%0d", i), 4'b0000, 4'b0000, 8'h00, 1'b0);
        end
        bus.req     = 4'b0001;
        bus.clr_req = 1'b0;
        clr_n       = 1'b1;

        // Reach WAIT, then pull reset between edges
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_async.ack", 32'(bus.ack), 32'h1);
        #2 clr_n = 1'b0;
        #1;
        check_all("async_rst", 4'b0000, 4'b0000, 8'h00, 1'b0);
        bus.req = 4'b0000;
        @(posedge clk); #1;
        clr_n = 1'b1;

        // Directed vector table
        for (int i = 0; i < 16; i++) begin
            bus.req     = vecs[i].req;
            bus.clr_req = vecs[i].clr;
            @(posedge clk); #1;
            check_all($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].ack, vecs[i].q, vecs[i].busy);
        end

        // Round-robin under full load; the owner drops req for one cycle after ack
        nack = 0;
        cyc  = 0;
        bus.req = 4'b1111;
        while (nack < 6 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.ack != 4'b0000) begin
                check($sformatf("rr%0d.ack", nack), 32'(bus.ack), 32'd1 << exp_order[nack]);
                check($sformatf("rr%0d.Q", nack), 32'(bus.Q), 32'(wd[exp_order[nack]]));
                nack++;
                bus.req = 4'b1111 & ~bus.ack;
            end else begin
                bus.req = 4'b1111;
            end
        end
        if (nack < 6) check("rr.timeout", 32'(nack), 32'd6);
        bus.req = 4'b0000;
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Randomized traffic against the reference model
        clr_n = 1'b0;
        @(posedge clk); #1;
        clr_n      = 1'b1;
        m_owner    = -1;
        m_acked    = 1'b0;
        m_clearing = 1'b0;
        m_last     = NREQ - 1;
        m_q        = 8'h00;
        for (int c = 0; c < 400; c++) begin
            req_r = 4'($urandom_range(0, 15));
            if (m_owner >= 0 && $urandom_range(0, 3) != 0) req_r[m_owner] = 1'b1;
            clr_r = ($urandom_range(0, 5) == 0);
            for (int i = 0; i < NREQ; i++) begin
                if (m_owner != i) bus.wdata[i*8 +: 8] = 8'($urandom);
            end
            bus.req     = req_r;
            bus.clr_req = clr_r;
            @(posedge clk);
            model_step(req_r, clr_r, bus.wdata);
            #1;
            e_gnt = (m_owner >= 0) ? 4'(4'b0001 << m_owner) : 4'b0000;
            e_ack = (m_owner >= 0 && m_acked) ? e_gnt : 4'b0000;
            check_all($sformatf("rnd%0d", c), e_gnt, e_ack, m_q, (m_owner >= 0) || m_clearing);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
